// File: rtl/sr_latch_driver_pkg.sv
// Shared types and default timing for the gated SR latch command stage.
// State encoding, op encoding and default phase lengths live here.
package sr_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      PULSE = 3'd2,
      HOLD  = 3'd3,
      CHECK = 3'd4
   } state_t;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

   localparam int SETUP_CYC_DEF = 1;
   localparam int EN_CYC_DEF    = 2;
   localparam int HOLD_CYC_DEF  = 1;
   localparam int CNT_W_DEF     = 4;

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request/status handshake plus the latch-side wires of the SR latch driver.
// slave: the driver itself; master: the requester together with the latch feedback.
interface sr_latch_driver_if;

   logic set_req;
   logic clr_req;
   logic q_fb;
   logic s;
   logic r;
   logic en;
   logic busy;
   logic done;
   logic err_fb;
   logic err_conflict;

   modport slave (
      input  set_req, clr_req, q_fb,
      output s, r, en, busy, done, err_fb, err_conflict
   );

   modport master (
      output set_req, clr_req, q_fb,
      input  s, r, en, busy, done, err_fb, err_conflict
   );

endinterface

// File: rtl/sr_latch_driver.sv
// Sequences a single set/clear request into setup / enable pulse / hold on a gated
// SR latch, then reads q back and reports done, feedback mismatch or request conflict.
module sr_latch_driver
   import sr_pkg::*;
#(
   parameter int SETUP_CYC = SETUP_CYC_DEF,
   parameter int EN_CYC    = EN_CYC_DEF,
   parameter int HOLD_CYC  = HOLD_CYC_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input logic               clk,
   input logic               rst,
   sr_latch_driver_if.slave  bus
);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             op_q, op_d;
   logic             s_q, s_d;
   logic             r_q, r_d;
   logic             en_q, en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_fb_q, err_fb_d;
   logic             err_conflict_q, err_conflict_d;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      op_d           = op_q;
      s_d            = s_q;
      r_d            = r_q;
      en_d           = en_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      err_fb_d       = 1'b0;
      err_conflict_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            // s/r are taken straight from the request so only one can ever be set
            if (bus.set_req ^ bus.clr_req) begin
               state_d = SETUP;
               op_d    = bus.set_req ? OP_SET : OP_CLR;
               s_d     = bus.set_req;
               r_d     = bus.clr_req;
               en_d    = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = SETUP_LD;
            end else if (bus.set_req && bus.clr_req) begin
               err_conflict_d = 1'b1;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = PULSE;
               en_d    = 1'b1;
               cnt_d   = EN_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         PULSE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               en_d    = 1'b0;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = CHECK;
               s_d     = 1'b0;
               r_d     = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         CHECK: begin
            // latch inputs are quiet here, so q_fb has settled to the written value
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            err_fb_d = (bus.q_fb != op_q);
         end
         default: begin
            state_d = IDLE;
            s_d     = 1'b0;
            r_d     = 1'b0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         op_q           <= OP_CLR;
         s_q            <= 1'b0;
         r_q            <= 1'b0;
         en_q           <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_fb_q       <= 1'b0;
         err_conflict_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         op_q           <= op_d;
         s_q            <= s_d;
         r_q            <= r_d;
         en_q           <= en_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_fb_q       <= err_fb_d;
         err_conflict_q <= err_conflict_d;
      end
   end

   assign bus.s            = s_q;
   assign bus.r            = r_q;
   assign bus.en           = en_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err_fb       = err_fb_q;
   assign bus.err_conflict = err_conflict_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Closed-loop bench for sr_latch_driver: a gated SR latch model feeds q back, and a
// transaction-level timing model predicts every output cycle by cycle.
module tb_sr_latch_driver;
   import sr_pkg::*;

   localparam int S = 1;
   localparam int E = 2;
   localparam int H = 1;
   localparam int L = S + E + H;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sr_latch_driver_if bus();

   sr_latch_driver #(
      .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic latch_q;
   bit   force_en;
   bit   force_val;

   // Reference: one active op described by its request cycle t0 and op value
   bit   act = 1'b0;
   int   t0 = 0;
   bit   op_m = 1'b0;
   bit   err_m = 1'b0;
   int   done_cyc = -1;
   int   conf_cyc = -1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h exp %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input bit set, input bit clr, input bit rs);
      int k;
      bit s_e, r_e, en_e, busy_e;
      @(negedge clk);
      if (bus.en) begin
         if (bus.s) latch_q = 1'b1;
         else if (bus.r) latch_q = 1'b0;
      end
      bus.q_fb = force_en ? force_val : latch_q;

      k      = cyc - t0;
      s_e    = act && k >= 1 && k <= L && op_m;
      r_e    = act && k >= 1 && k <= L && !op_m;
      en_e   = act && k >= S + 1 && k <= S + E;
      busy_e = act && k >= 1 && k <= L + 1;
      chk("s", bus.s, s_e);
      chk("r", bus.r, r_e);
      chk("en", bus.en, en_e);
      chk("busy", bus.busy, busy_e);
      chk("done", bus.done, cyc == done_cyc);
      chk("err_fb", bus.err_fb, (cyc == done_cyc) && err_m);
      chk("err_conflict", bus.err_conflict, cyc == conf_cyc);
      chk("inv_sr", bus.s & bus.r, 0);
      chk("inv_en", bus.en & ~(bus.s ^ bus.r), 0);

      if (act && k == L + 1) err_m = (bus.q_fb != op_m);

      bus.set_req = set;
      bus.clr_req = clr;
      rst         = rs;
      if (rs) begin
         act      = 1'b0;
         done_cyc = -1;
         conf_cyc = -1;
      end else if (!act || k >= L + 2) begin
         if (set ^ clr) begin
            act      = 1'b1;
            t0       = cyc;
            op_m     = set;
            done_cyc = cyc + L + 2;
         end else if (set && clr) begin
            conf_cyc = cyc + 1;
         end
      end
      cyc++;
   endtask

   initial begin
      rst         = 1'b1;
      bus.set_req = 1'b0;
      bus.clr_req = 1'b0;
      bus.q_fb    = 1'b0;
      latch_q     = 1'b0;
      force_en    = 1'b0;
      force_val   = 1'b0;
      repeat (2) @(posedge clk);
      step(0, 0, 1);
      step(0, 0, 0);

      // set with the latch attached
      step(1, 0, 0);
      repeat (8) step(0, 0, 0);
      chk("latch_q_set", latch_q, 1);

      // clear while q_fb is stuck high
      force_en  = 1'b1;
      force_val = 1'b1;
      step(0, 1, 0);
      repeat (8) step(0, 0, 0);
      force_en = 1'b0;
      chk("latch_q_clr", latch_q, 0);

      // conflicting requests
      step(1, 1, 0);
      repeat (4) step(0, 0, 0);

      // clear request while busy is dropped
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 1, 0);
      repeat (6) step(0, 0, 0);

      // reset mid-pulse
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      repeat (8) step(0, 0, 0);

      // back-to-back with set held
      repeat (14) step(1, 0, 0);
      repeat (8) step(0, 0, 0);

      // randomized traffic, occasional reset and stuck feedback
      repeat (600) begin
         if ($urandom_range(0, 15) == 0) force_en = !force_en;
         force_val = 1'($urandom_range(0, 1));
         step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 60) == 0);
      end
      force_en = 1'b0;
      repeat (10) step(0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
